// File: rtl/fsb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fsb_master
// Description : Single-outstanding FSB bus master (IDLE/T1/T2/RESP), bridging
//               a valid/ready request port to an FSB target. Optional T2
//               timeout is enabled with macro FSB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fsb_master #(
    parameter int FSB_ADDR_WIDTH = 32,
    parameter int FSB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [FSB_ADDR_WIDTH-3:0] req_addr,
    input  logic [FSB_DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]                req_nbe,
    input  logic                      req_w_nr,
    input  logic                      req_m_nio,
    input  logic                      req_d_nc,
    output logic                      rsp_valid,
    output logic [FSB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_error,
    output logic [FSB_ADDR_WIDTH-3:0] FSB_addr,
    output logic [FSB_DATA_WIDTH-1:0] FSB_data_o,
    input  logic [FSB_DATA_WIDTH-1:0] FSB_data_i,
    output logic [3:0]                FSB_NBE,
    output logic                      FSB_W_NR,
    output logic                      FSB_M_NIO,
    output logic                      FSB_D_NC,
    output logic                      FSB_NADS,
    input  logic                      FSB_NRDY
);

    localparam int C_LANE_W = FSB_DATA_WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                      w_accept;
    logic                      w_null;
    logic                      w_done;
    logic                      w_timeout;
    logic                      w_limit;
    logic                      w_bus;

    logic [3:0]                r_nbe;
    logic                      r_w_nr;
    logic                      r_m_nio;
    logic                      r_d_nc;
    logic [FSB_ADDR_WIDTH-3:0] r_fsb_addr;
    logic [FSB_DATA_WIDTH-1:0] r_fsb_data;
    logic [FSB_DATA_WIDTH-1:0] r_rdata;
    logic [FSB_DATA_WIDTH-1:0] w_wmask;
    logic [FSB_DATA_WIDTH-1:0] w_rmask;

    // Byte-lane masks: a lane is kept only when its active-low enable is 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_wmask[gi*C_LANE_W +: C_LANE_W] = {C_LANE_W{~req_nbe[gi]}};
        assign w_rmask[gi*C_LANE_W +: C_LANE_W] = {C_LANE_W{~r_nbe[gi]}};
    end

    assign w_null = (req_nbe == 4'hF);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_null ? S_RESP : S_T1;
                end
            end
            S_T1: begin
                w_next = S_T2;
            end
            S_T2: begin
                // Target ready wins over a simultaneous timeout.
                if (!FSB_NRDY) begin
                    w_done = 1'b1;
                    w_next = S_RESP;
                end else if (w_limit) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_nbe      <= 4'hF;
            r_w_nr     <= 1'b0;
            r_m_nio    <= 1'b0;
            r_d_nc     <= 1'b0;
            r_fsb_addr <= '0;
            r_fsb_data <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_nbe   <= req_nbe;
                r_w_nr  <= req_w_nr;
                r_m_nio <= req_m_nio;
                r_d_nc  <= req_d_nc;
                if (w_null) begin
                    r_rdata <= '0;
                end else begin
                    // Bus-facing address/data only move when a real bus cycle starts.
                    r_fsb_addr <= req_addr;
                    if (req_w_nr) begin
                        r_fsb_data <= req_wdata & w_wmask;
                    end
                end
            end
            if (w_done) begin
                r_rdata <= r_w_nr ? '0 : (FSB_data_i & w_rmask);
            end
            if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

`ifdef FSB_MASTER_TIMEOUT_EN
    localparam logic [8:0] C_LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] r_cnt;
    logic       r_err;

    // Counter holds the number of NRDY-high T2 cycles already elapsed.
    assign w_limit = (({1'b0, r_cnt} + 9'd1) >= C_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_T1) begin
                r_cnt <= 8'd0;
            end else if ((r_state == S_T2) && FSB_NRDY) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_done || (w_accept && w_null)) begin
                r_err <= 1'b0;
            end
        end
    end

    assign rsp_error = r_err;
`else
    logic [8:0] w_unused_timeout;

    assign w_unused_timeout = 9'(TIMEOUT_CYCLES);
    assign w_limit          = 1'b0;
    assign rsp_error        = 1'b0;
`endif

    assign w_bus      = (r_state == S_T1) || (r_state == S_T2);
    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_rdata  = r_rdata;
    assign FSB_NADS   = (r_state != S_T1);
    assign FSB_NBE    = w_bus ? r_nbe : 4'hF;
    assign FSB_W_NR   = w_bus & r_w_nr;
    assign FSB_M_NIO  = w_bus & r_m_nio;
    assign FSB_D_NC   = w_bus & r_d_nc;
    assign FSB_addr   = r_fsb_addr;
    assign FSB_data_o = r_fsb_data;

endmodule
`default_nettype wire

// File: tb/tb_fsb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fsb_master
// Description : Self-checking bench for fsb_master: per-transaction timeline
//               model plus literal checks for the key bus scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsb_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    wire         req_ready;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_nbe;
    logic        req_w_nr, req_m_nio, req_d_nc;
    wire         rsp_valid;
    wire  [31:0] rsp_rdata;
    wire         rsp_error;
    wire  [29:0] FSB_addr;
    wire  [31:0] FSB_data_o;
    logic [31:0] FSB_data_i;
    wire  [3:0]  FSB_NBE;
    wire         FSB_W_NR, FSB_M_NIO, FSB_D_NC, FSB_NADS;
    logic        FSB_NRDY;

    fsb_master #(
        .FSB_ADDR_WIDTH(32),
        .FSB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_nbe(req_nbe),
        .req_w_nr(req_w_nr), .req_m_nio(req_m_nio), .req_d_nc(req_d_nc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .FSB_addr(FSB_addr), .FSB_data_o(FSB_data_o), .FSB_data_i(FSB_data_i),
        .FSB_NBE(FSB_NBE), .FSB_W_NR(FSB_W_NR), .FSB_M_NIO(FSB_M_NIO),
        .FSB_D_NC(FSB_D_NC), .FSB_NADS(FSB_NADS), .FSB_NRDY(FSB_NRDY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc, vcyc, valid_cnt, nads_cnt;
    logic [31:0] last_rdata;
    logic        last_err;
    bit          chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_ready, e_valid, e_nads, e_err;
    logic [3:0]  e_nbe;
    logic [2:0]  e_ctrl;
    logic [29:0] e_addr;
    logic [31:0] e_data, e_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] nbe);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = nbe[i] ? 8'h00 : 8'hFF;
        return m;
    endfunction

    task automatic set_idle();
        e_ready = 1'b1; e_valid = 1'b0; e_nads = 1'b1;
        e_nbe = 4'hF; e_ctrl = 3'b000;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, e_ready});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
            chk("nads", {31'd0, FSB_NADS}, {31'd0, e_nads});
            chk("nbe", {28'd0, FSB_NBE}, {28'd0, e_nbe});
            chk("ctrl", {29'd0, FSB_W_NR, FSB_M_NIO, FSB_D_NC}, {29'd0, e_ctrl});
            chk("fsb_addr", {2'd0, FSB_addr}, {2'd0, e_addr});
            chk("fsb_data_o", FSB_data_o, e_data);
            if (e_valid) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, e_err});
            end
        end
        if (rsp_valid === 1'b1) begin
            valid_cnt++;
            vcyc       = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_error;
        end
        if (FSB_NADS === 1'b0) nads_cnt++;
    end

    // Called one step after a rising edge in an idle cycle. abort_k >= 0 pulses
    // reset during that T2 cycle index instead of finishing normally.
    task automatic do_txn(input logic [29:0] a, input logic [31:0] d, input logic [3:0] nbe,
                          input logic [2:0] ctl, input int waits, input logic [31:0] td,
                          input int abort_k);
        int t2;
        bit to;
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_nbe = nbe;
        {req_w_nr, req_m_nio, req_d_nc} = ctl;
        FSB_NRDY = 1'($urandom); FSB_data_i = $urandom;
        @(posedge clk); #1;
        acc = cyc; nads_cnt = 0; valid_cnt = 0; vcyc = -100;
        // Request port is ignored while busy; drive junk on it.
        req_valid = 1'($urandom); req_addr = 30'($urandom); req_wdata = $urandom;
        req_nbe = 4'($urandom); {req_w_nr, req_m_nio, req_d_nc} = 3'($urandom);
        e_ready = 1'b0;
        if (nbe == 4'hF) begin
            e_valid = 1'b1; e_rdata = 32'd0; e_err = 1'b0;
            @(posedge clk); #1;
            set_idle(); req_valid = 1'b0;
            return;
        end
        e_addr = a;
        if (ctl[2]) e_data = d & lane_mask(nbe);
        e_nads = 1'b0; e_nbe = nbe; e_ctrl = ctl;
        @(posedge clk); #1;
        e_nads = 1'b1;
        t2 = waits + 1;
        to = 1'b0;
`ifdef FSB_MASTER_TIMEOUT_EN
        if (waits >= TO) begin t2 = TO; to = 1'b1; end
`endif
        for (int k = 0; k < t2; k++) begin
            FSB_NRDY   = (k == waits) ? 1'b0 : 1'b1;
            FSB_data_i = (k == waits) ? td : $urandom;
            if (k == abort_k) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                e_addr = 30'd0; e_data = 32'd0;
                set_idle(); req_valid = 1'b0; FSB_NRDY = 1'($urandom);
                return;
            end
            @(posedge clk); #1;
        end
        FSB_NRDY = 1'($urandom); FSB_data_i = $urandom;
        e_valid = 1'b1; e_ready = 1'b0; e_nads = 1'b1; e_nbe = 4'hF; e_ctrl = 3'b000;
        e_err   = to;
        e_rdata = (to || ctl[2]) ? 32'd0 : (td & lane_mask(nbe));
        @(posedge clk); #1;
        set_idle(); req_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] rn;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_nbe = 4'hF;
        req_w_nr = 1'b0; req_m_nio = 1'b0; req_d_nc = 1'b0;
        FSB_NRDY = 1'b1; FSB_data_i = '0;
        set_idle(); e_addr = 30'd0; e_data = 32'd0; e_rdata = 32'd0; e_err = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_nads_nbe", {27'd0, FSB_NADS, FSB_NBE}, 32'h1F);
        chk("reset_addr", {2'd0, FSB_addr}, 32'd0);

        // IO read at byte address 0x04
        do_txn(30'h1, 32'h0, 4'h0, 3'b001, 0, 32'hDEADBEEF, -1);
        chk("ioread_latency", 32'(vcyc - acc + 1), 32'd3);
        chk("ioread_rdata", last_rdata, 32'hDEADBEEF);
        chk("ioread_nads_cycles", 32'(nads_cnt), 32'd1);

        // null request after a read that left nonzero data
        do_txn(30'h155, 32'hFFFF_FFFF, 4'hF, 3'b101, 0, 32'h0, -1);
        chk("null_latency", 32'(vcyc - acc + 1), 32'd1);
        chk("null_nads_cycles", 32'(nads_cnt), 32'd0);
        chk("null_rdata_err", {last_err, last_rdata[30:0]}, 32'd0);

        // masked memory write
        do_txn(30'h2A0, 32'h11223344, 4'b1010, 3'b111, 0, 32'hCAFEF00D, -1);
        chk("mwrite_data_o", FSB_data_o, 32'h00220044);
        chk("mwrite_rdata", last_rdata, 32'd0);

        // five wait states
        do_txn(30'h3, 32'h0, 4'h0, 3'b011, 5, 32'h0BADC0DE, -1);
        chk("wait5_latency", 32'(vcyc - acc + 1), 32'd8);

`ifdef FSB_MASTER_TIMEOUT_EN
        do_txn(30'h7, 32'h0, 4'h0, 3'b011, 20, 32'h12345678, -1);
        chk("timeout_latency", 32'(vcyc - acc + 1), 32'd6);
        chk("timeout_err", {31'd0, last_err}, 32'd1);
        chk("timeout_rdata", last_rdata, 32'd0);
`else
        do_txn(30'h7, 32'h0, 4'h0, 3'b011, 40, 32'h12345678, -1);
        chk("no_timeout_latency", 32'(vcyc - acc + 1), 32'd43);
        chk("no_timeout_err", {31'd0, last_err}, 32'd0);
`endif

        // reset in the third T2 cycle
        do_txn(30'h9, 32'h5555AAAA, 4'h0, 3'b110, 10, 32'h0, 2);
        chk("abort_no_valid", 32'(valid_cnt), 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_nads_nbe", {27'd0, FSB_NADS, FSB_NBE}, 32'h1F);

        for (int n = 0; n < 60; n++) begin
            rn = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            do_txn(30'($urandom), $urandom, rn, 3'($urandom),
                   int'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 15) == 0) ? 0 : -1);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                FSB_NRDY = 1'($urandom);
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
